// File: rtl/fetch_controller_if.sv
// Fetch-side bus: instruction memory port, decode handshake and branch redirect.
interface fetch_controller_if;
  logic [31:0] imem_endereco;
  logic [31:0] imem_instrucao;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instrucao;
  logic [31:0] dec_pc;
  logic        desvio_valid;
  logic [31:0] desvio_alvo;

  modport master (
    output imem_endereco,
    input  imem_instrucao,
    output dec_valid,
    input  dec_ready,
    output dec_instrucao,
    output dec_pc,
    input  desvio_valid,
    input  desvio_alvo
  );

  modport slave (
    input  imem_endereco,
    output imem_instrucao,
    input  dec_valid,
    output dec_ready,
    input  dec_instrucao,
    input  dec_pc,
    output desvio_valid,
    output desvio_alvo
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, queues {pc, instr} in a 2-entry
// buffer toward decode, and handles redirects, halt and illegal fetches.
module fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MEM_WORDS  = 13,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  fetch_controller_if.master         bus,
  output logic                       halted,
  output logic                       fault,
  output logic [31:0]                fetch_count
);

  typedef enum logic [1:0] {OCIOSO, BUSCA, PARADO, FALHA} state_t;

  localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] buf_instr [2];
  logic [31:0] buf_pc    [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;

  logic redirect, pop, push, flush, illegal, is_halt;

  assign bus.imem_endereco = pc;
  assign bus.dec_valid     = (count != 2'd0);
  assign bus.dec_instrucao = buf_instr[rd_ptr];
  assign bus.dec_pc        = buf_pc[rd_ptr];
  assign halted            = (state == PARADO);
  assign fault             = (state == FALHA);

  assign redirect = bus.desvio_valid && ((state == BUSCA) || (state == PARADO));
  assign illegal  = (pc[1:0] != 2'b00) || (pc[31:2] >= MEM_LIMIT);
  assign is_halt  = (bus.imem_instrucao == HALT_INSTR);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    flush     = 1'b0;
    // A redirect cycle suppresses the pop as well as any fetch.
    pop       = bus.dec_valid && bus.dec_ready && !redirect;
    if (redirect) begin
      flush     = 1'b1;
      pc_nxt    = bus.desvio_alvo;
      state_nxt = BUSCA;
    end else begin
      unique case (state)
        OCIOSO: if (run) state_nxt = BUSCA;
        BUSCA: begin
          if ((count != 2'd2) || pop) begin
            if (illegal) begin
              state_nxt = FALHA;
            end else if (is_halt) begin
              state_nxt = PARADO;
            end else begin
              push   = 1'b1;
              pc_nxt = pc + 32'd4;
            end
          end
        end
        PARADO: ;
        FALHA:  ;
        default: state_nxt = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= OCIOSO;
      pc          <= RESET_PC;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      fetch_count <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          buf_instr[wr_ptr] <= bus.imem_instrucao;
          buf_pc[wr_ptr]    <= pc;
          wr_ptr            <= ~wr_ptr;
          fetch_count       <= fetch_count + 32'd1;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count + 2'(push) - 2'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed vector bench for fetch_controller with a combinational memory model.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        halted, fault;
  logic [31:0] fetch_count;
  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  fetch_controller_if bus ();

  fetch_controller #(
    .RESET_PC   (32'h0000_0000),
    .MEM_WORDS  (13),
    .HALT_INSTR (32'hFFFF_FFFF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .bus         (bus.master),
    .halted      (halted),
    .fault       (fault),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  always_comb bus.imem_instrucao = mem[bus.imem_endereco[9:2]];

  localparam logic [31:0] M0  = 32'h0000_0013;
  localparam logic [31:0] M1  = 32'h0010_0093;
  localparam logic [31:0] M2  = 32'h0020_0113;
  localparam logic [31:0] M8  = 32'h0080_0413;
  localparam logic [31:0] M12 = 32'h00C0_0613;

  typedef struct {
    bit          rst;
    bit          run;
    bit          rdy;
    bit          dv;
    logic [31:0] alvo;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] ein;
    bit          eh;
    bit          ef;
    logic [31:0] ea;
    logic [31:0] ec;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(bit rst, bit r, bit rdy, bit dv, logic [31:0] alvo,
                              bit ev, logic [31:0] epc, logic [31:0] ein,
                              bit eh, bit ef, logic [31:0] ea, logic [31:0] ec);
    vec_t v;
    v.rst = rst; v.run = r; v.rdy = rdy; v.dv = dv; v.alvo = alvo;
    v.ev = ev; v.epc = epc; v.ein = ein; v.eh = eh; v.ef = ef; v.ea = ea; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    bus.dec_ready = 1'b0;
    bus.desvio_valid = 1'b0;
    bus.desvio_alvo = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    mem[0] = M0; mem[1] = M1; mem[2] = M2; mem[3] = 32'hFFFF_FFFF;
    mem[8] = M8; mem[12] = M12;
    bus.dec_ready = 1'b0;
    bus.desvio_valid = 1'b0;
    bus.desvio_alvo = '0;

    // Normal drain, then redirect out of PARADO
    vecs.push_back(mk(1,1,1,0,0,      0,0,0,      0,0,32'h00,0));
    vecs.push_back(mk(0,0,1,0,0,      1,32'h00,M0,0,0,32'h04,1));
    vecs.push_back(mk(0,0,1,0,0,      1,32'h04,M1,0,0,32'h08,2));
    vecs.push_back(mk(0,0,1,0,0,      1,32'h08,M2,0,0,32'h0C,3));
    vecs.push_back(mk(0,0,1,0,0,      0,0,0,      1,0,32'h0C,3));
    vecs.push_back(mk(0,0,1,0,0,      0,0,0,      1,0,32'h0C,3));
    vecs.push_back(mk(0,0,1,1,32'h20, 0,0,0,      0,0,32'h20,3));
    vecs.push_back(mk(0,0,1,0,0,      1,32'h20,M8,0,0,32'h24,4));
    // Backpressure: 5 cycles of dec_ready=0, then release
    vecs.push_back(mk(1,1,0,0,0,      0,0,0,      0,0,32'h00,0));
    vecs.push_back(mk(0,0,0,0,0,      1,32'h00,M0,0,0,32'h04,1));
    vecs.push_back(mk(0,0,0,0,0,      1,32'h00,M0,0,0,32'h08,2));
    vecs.push_back(mk(0,0,0,0,0,      1,32'h00,M0,0,0,32'h08,2));
    vecs.push_back(mk(0,0,0,0,0,      1,32'h00,M0,0,0,32'h08,2));
    vecs.push_back(mk(0,0,0,0,0,      1,32'h00,M0,0,0,32'h08,2));
    vecs.push_back(mk(0,0,1,0,0,      1,32'h04,M1,0,0,32'h0C,3));
    vecs.push_back(mk(0,0,1,0,0,      1,32'h08,M2,1,0,32'h0C,3));
    vecs.push_back(mk(0,0,1,0,0,      0,0,0,      1,0,32'h0C,3));
    // Redirect with full buffer, then misaligned fault and ignored redirect
    vecs.push_back(mk(1,1,0,0,0,      0,0,0,      0,0,32'h00,0));
    vecs.push_back(mk(0,0,0,0,0,      1,32'h00,M0,0,0,32'h04,1));
    vecs.push_back(mk(0,0,0,0,0,      1,32'h00,M0,0,0,32'h08,2));
    vecs.push_back(mk(0,0,0,1,32'h20, 0,0,0,      0,0,32'h20,2));
    vecs.push_back(mk(0,0,0,0,0,      1,32'h20,M8,0,0,32'h24,3));
    vecs.push_back(mk(0,0,0,1,32'h22, 0,0,0,      0,0,32'h22,3));
    vecs.push_back(mk(0,0,0,0,0,      0,0,0,      0,1,32'h22,3));
    vecs.push_back(mk(0,0,0,1,32'h00, 0,0,0,      0,1,32'h22,3));
    vecs.push_back(mk(0,0,1,0,0,      0,0,0,      0,1,32'h22,3));
    // Last legal word, then running off the end while draining
    vecs.push_back(mk(1,1,1,0,0,      0,0,0,      0,0,32'h00,0));
    vecs.push_back(mk(0,0,1,1,32'h30, 0,0,0,      0,0,32'h30,0));
    vecs.push_back(mk(0,0,1,0,0,      1,32'h30,M12,0,0,32'h34,1));
    vecs.push_back(mk(0,0,1,0,0,      0,0,0,      0,1,32'h34,1));
    // Redirect straight to word 13
    vecs.push_back(mk(1,1,1,0,0,      0,0,0,      0,0,32'h00,0));
    vecs.push_back(mk(0,0,1,1,32'h34, 0,0,0,      0,0,32'h34,0));
    vecs.push_back(mk(0,0,1,0,0,      0,0,0,      0,1,32'h34,0));

    // Reset values
    do_reset();
    chk("rst_valid", -1, 32'(bus.dec_valid), 0);
    chk("rst_addr",  -1, bus.imem_endereco, 32'h0);
    chk("rst_instr", -1, bus.dec_instrucao, 32'h0);
    chk("rst_pc",    -1, bus.dec_pc, 32'h0);
    chk("rst_halt",  -1, 32'(halted), 0);
    chk("rst_fault", -1, 32'(fault), 0);
    chk("rst_count", -1, fetch_count, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      run = vecs[i].run;
      bus.dec_ready = vecs[i].rdy;
      bus.desvio_valid = vecs[i].dv;
      bus.desvio_alvo = vecs[i].alvo;
      step();
      chk("valid", i, 32'(bus.dec_valid), 32'(vecs[i].ev));
      if (vecs[i].ev) begin
        chk("dec_pc", i, bus.dec_pc, vecs[i].epc);
        chk("dec_instr", i, bus.dec_instrucao, vecs[i].ein);
      end
      chk("halted", i, 32'(halted), 32'(vecs[i].eh));
      chk("fault", i, 32'(fault), 32'(vecs[i].ef));
      chk("addr", i, bus.imem_endereco, vecs[i].ea);
      chk("fetch_count", i, fetch_count, vecs[i].ec);
    end

    // Asynchronous reset with two entries buffered
    do_reset();
    run = 1'b1;
    bus.dec_ready = 1'b0;
    step();
    run = 1'b0;
    step();
    step();
    chk("pre_rst_valid", -2, 32'(bus.dec_valid), 1);
    chk("pre_rst_count", -2, fetch_count, 2);
    #3 rst_n = 1'b0;
    #1;
    chk("async_valid", -2, 32'(bus.dec_valid), 0);
    chk("async_addr",  -2, bus.imem_endereco, 32'h0);
    chk("async_instr", -2, bus.dec_instrucao, 32'h0);
    chk("async_pc",    -2, bus.dec_pc, 32'h0);
    chk("async_count", -2, fetch_count, 0);
    chk("async_halt",  -2, 32'(halted), 0);
    chk("async_fault", -2, 32'(fault), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.dec_ready = 1'b1;
    repeat (3) step();
    chk("idle_valid", -3, 32'(bus.dec_valid), 0);
    chk("idle_addr",  -3, bus.imem_endereco, 32'h0);
    chk("idle_count", -3, fetch_count, 0);
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    chk("restart_valid", -4, 32'(bus.dec_valid), 1);
    chk("restart_pc",    -4, bus.dec_pc, 32'h0);
    chk("restart_instr", -4, bus.dec_instrucao, M0);
    chk("restart_count", -4, fetch_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the word-addressed, combinational instruction memory (13 words, byte address bits [9:2] select the word) for the processor core. It owns the program counter and drives the memory address. It queues fetched instructions with their PC in a 2-entry buffer toward decode under a valid/ready handshake. It also handles branch redirects, halt detection and out-of-range/misaligned fetch faults.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- MEM_WORDS, 13, number of valid instruction words; a fetch is legal only when word index pc[31:2] < MEM_WORDS.
- HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetching.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  level; starts fetching from the OCIOSO state.
- imem_endereco  output  32  byte address to the instruction memory; equals pc (combinational from the register).
- imem_instrucao  input  32  instruction word returned combinationally for imem_endereco.
- dec_valid  output  1  buffer head holds a valid entry.
- dec_ready  input  1  decode accepts the head this cycle.
- dec_instrucao  output  32  instruction at the buffer head.
- dec_pc  output  32  PC of the buffer head.
- desvio_valid  input  1  redirect request, 1-cycle pulse.
- desvio_alvo  input  32  redirect target byte address.
- halted  output  1  high while in PARADO.
- fault  output  1  high while in FALHA.
- fetch_count  output  32  number of instructions pushed into the buffer; wraps modulo 2^32.

## Operation
- States:
  - OCIOSO: after reset.
  - BUSCA: fetching.
  - PARADO: halt seen.
  - FALHA: illegal fetch.
- OCIOSO -> BUSCA when run=1. Redirects are ignored in OCIOSO.
- Fetch attempts occur only in BUSCA, and only when the buffer can accept an entry: count<2, or count==2 with a pop this cycle (dec_valid && dec_ready).
- Fetch checks, evaluated in this order:
  - pc[1:0]!=0 or pc[31:2]>=MEM_WORDS: go to FALHA. No push; pc holds.
  - imem_instrucao==HALT_INSTR: go to PARADO. The halt word is not pushed; pc holds.
  - Otherwise: push {pc, imem_instrucao}, set pc<=pc+4 (32-bit wrap), and increment fetch_count.
- Redirect (desvio_valid=1) in BUSCA or PARADO:
  - It has priority over any fetch or pop that cycle.
  - The buffer is flushed (count<=0) and pc<=desvio_alvo.
  - The state becomes BUSCA. Nothing is pushed that cycle.
  - Target alignment and range are checked at the next fetch attempt.
- FALHA is left only by reset. Redirects are ignored in FALHA.
- Buffer:
  - 2-entry FIFO in order; outputs show the head.
  - A pop happens on dec_valid && dec_ready, except in a redirect cycle.
  - In PARADO and FALHA, entries already in the buffer keep draining normally.
  - Simultaneous push and pop at count==2 keeps count at 2.
- Reset (asynchronous, may arrive mid-operation):
  - State OCIOSO, pc=RESET_PC, buffer empty, fetch_count=0.
  - Outputs: dec_valid=0, halted=0, fault=0.
  - dec_instrucao=0 and dec_pc=0 (storage cleared).
  - imem_endereco=RESET_PC.

## Timing
- run sampled high at edge N: state is BUSCA after N. The first push happens at edge N+1, so dec_valid=1 after N+1.
- With dec_ready held at 1, one instruction is delivered per cycle with no bubbles.
- Redirect sampled at edge R: dec_valid=0 after R. The target instruction is pushed at R+1 and is visible after R+1 (1-cycle bubble).
- Halt word at pc sampled at edge H: halted=1 after H. Earlier entries remain valid until popped.
- Fault detected at edge F: fault=1 after F.
- dec_ready held at 0: the buffer fills after 2 pushes. pc then stalls on the third instruction's address until a pop.
- Outputs are registered or derived directly from registers. No combinational path from dec_ready or desvio_valid to dec_valid.

## Test plan
- Normal drain:
  - Stimulus: memory words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0xFFFFFFFF. Release reset, pulse run, dec_ready=1.
  - Required: dec_pc sequence 0, 4, 8 with matching instructions; then halted=1, fetch_count=3, and imem_endereco holds at 12.
- Backpressure:
  - Stimulus: dec_ready=0 for 5 cycles after run, then 1.
  - Required: exactly 2 entries are buffered (pc=0,4); imem_endereco stays at 8. After release, 0, 4, 8 are delivered in order with none lost or duplicated.
- Redirect:
  - Stimulus: with the buffer full, pulse desvio_valid with desvio_alvo=0x20.
  - Required: dec_valid=0 the next cycle; the following delivered entry has dec_pc=0x20 and instruction memory[8].
- Faults:
  - Stimulus 1: redirect to 0x22 (misaligned). Required: fault=1, no push, and later redirects are ignored.
  - Stimulus 2: after reset, redirect to 0x34 (word 13). Required: fault=1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously while dec_valid=1 with 2 entries buffered.
  - Required: outputs take their reset values immediately (before the next clk edge), fetch_count=0, state OCIOSO, and no fetch occurs until run is asserted.
